// File: rtl/col2im_2d.sv
// col2im_2d: streaming inverse of the im2col unfold.
//
// Each accepted column holds KERNEL_SIZE*KERNEL_SIZE values for one kernel position.
// All of them are added into an image-sized accumulator buffer in a single cycle.
// Kernel positions are visited in raster order, and overlapping patches sum.
// After the last position the image drains row-major, one pixel per handshake.
// Each drained pixel is cleared, so the buffer is zero again when the next frame starts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   column handshake (ready only while accumulating)
//   in_column           packed [0:K*K-1][DATA_WIDTH-1:0]; element i -> patch (i/K, i%K)
//   out_valid/out_ready pixel handshake (valid only while draining)
//   out_pixel           accumulated pixel, ACC_WIDTH bits
//   out_last            marks pixel H*W-1
//   busy                high unless idle in accumulate with no columns taken
//
// Build option:
//   COL2IM_SATURATE_EN  when defined, accumulator updates clamp at 2^ACC_WIDTH-1
//                       instead of wrapping.
module col2im_2d #(
    parameter int unsigned IMAGE_WIDTH  = 4,
    parameter int unsigned IMAGE_HEIGHT = 4,
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH    = 12
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [0:KERNEL_SIZE*KERNEL_SIZE-1][DATA_WIDTH-1:0]     in_column,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [ACC_WIDTH-1:0]                                   out_pixel,
    output logic                                                   out_last,
    output logic                                                   busy
);

    localparam int unsigned HORIZONTAL_POSITIONS = (IMAGE_WIDTH - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned VERTICAL_POSITIONS   = (IMAGE_HEIGHT - KERNEL_SIZE) / STRIDE + 1;
    localparam int unsigned KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned PXW  = (HORIZONTAL_POSITIONS > 1) ? $clog2(HORIZONTAL_POSITIONS) : 1;
    localparam int unsigned PYW  = (VERTICAL_POSITIONS > 1) ? $clog2(VERTICAL_POSITIONS) : 1;
    localparam int unsigned IDXW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    typedef enum logic {StAccum, StDrain} state_e;

    state_e               state_q, state_d;
    logic [PXW-1:0]       pos_x_q, pos_x_d;
    logic [PYW-1:0]       pos_y_q, pos_y_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [ACC_WIDTH-1:0] acc_q [NUM_PIXELS];
    logic [ACC_WIDTH-1:0] acc_d [NUM_PIXELS];

    logic        in_fire;
    logic        out_fire;
    logic        last_x;
    logic        last_y;
    int unsigned tgt;

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
`ifdef COL2IM_SATURATE_EN
        logic [ACC_WIDTH:0] sum;
        // One extra bit catches the carry; clamp when it is set.
        sum = {1'b0, a} + (ACC_WIDTH + 1)'(b);
        return sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'(b);
`endif
    endfunction

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDrain);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_x    = (pos_x_q == PXW'(HORIZONTAL_POSITIONS - 1));
    assign last_y    = (pos_y_q == PYW'(VERTICAL_POSITIONS - 1));
    assign out_pixel = out_valid ? acc_q[idx_q] : '0;
    assign out_last  = out_valid && (idx_q == IDXW'(NUM_PIXELS - 1));
    assign busy      = (state_q == StDrain) || (pos_x_q != '0) || (pos_y_q != '0);

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        tgt     = 0;
        unique case (state_q)
            StAccum: begin
                if (in_fire) begin
                    // Targets within one column are distinct, so sequential
                    // read-modify-write on acc_d equals K*K parallel updates.
                    for (int unsigned i = 0; i < KK; i++) begin
                        tgt = (32'(pos_y_q) * STRIDE + i / KERNEL_SIZE) * IMAGE_WIDTH
                            + 32'(pos_x_q) * STRIDE + i % KERNEL_SIZE;
                        acc_d[IDXW'(tgt)] = acc_add(acc_d[IDXW'(tgt)], in_column[i]);
                    end
                    if (last_x && last_y) begin
                        pos_x_d = '0;
                        pos_y_d = '0;
                        state_d = StDrain;
                    end else if (last_x) begin
                        pos_x_d = '0;
                        pos_y_d = pos_y_q + 1'b1;
                    end else begin
                        pos_x_d = pos_x_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_fire) begin
                    // Clear on read leaves the buffer zeroed for the next frame.
                    acc_d[idx_q] = '0;
                    if (idx_q == IDXW'(NUM_PIXELS - 1)) begin
                        idx_d   = '0;
                        state_d = StAccum;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
            pos_x_q <= '0;
            pos_y_q <= '0;
            idx_q   <= '0;
            for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_col2im_2d.sv
`timescale 1ns/1ps
module tb_col2im_2d;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef COL2IM_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // a: defaults (4x4, K=3, S=1, ACC 12)
    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
    logic [0:8][7:0] a_col;
    logic [11:0]     a_pix;
    // b: 5x5, K=3, S=2
    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
    logic [0:8][7:0] b_col;
    logic [11:0]     b_pix;
    // c: defaults with ACC_WIDTH=9
    logic            c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_last, c_busy;
    logic [0:8][7:0] c_col;
    logic [8:0]      c_pix;

    col2im_2d dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_column(a_col), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pixel(a_pix), .out_last(a_last), .busy(a_busy)
    );

    col2im_2d #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL_SIZE(3), .STRIDE(2),
                .DATA_WIDTH(8), .ACC_WIDTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_column(b_col), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pixel(b_pix), .out_last(b_last), .busy(b_busy)
    );

    col2im_2d #(.ACC_WIDTH(9)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_column(c_col), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_pixel(c_pix), .out_last(c_last), .busy(c_busy)
    );

    // Reference image: plain scatter-add of each patch at its raster position.
    int ref_img[25];

    function automatic void ref_clear();
        for (int i = 0; i < 25; i++) ref_img[i] = 0;
    endfunction

    function automatic void ref_scatter(input int w, input int s, input int hpos, input int p,
                                        input logic [0:8][7:0] col, input int acc_w);
        int px, py, t, v, maxv;
        px   = p % hpos;
        py   = p / hpos;
        maxv = (1 << acc_w) - 1;
        for (int i = 0; i < 9; i++) begin
            t = (py * s + i / 3) * w + px * s + i % 3;
            v = ref_img[t] + int'(col[i]);
            if (SAT) v = (v > maxv) ? maxv : v;
            else     v = v % (maxv + 1);
            ref_img[t] = v;
        end
    endfunction

    function automatic logic [0:8][7:0] fill_col(input int val);
        logic [0:8][7:0] c;
        for (int i = 0; i < 9; i++) c[i] = 8'(val);
        return c;
    endfunction

    function automatic logic [0:8][7:0] rand_col();
        logic [0:8][7:0] c;
        for (int i = 0; i < 9; i++) c[i] = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic push_a(input logic [0:8][7:0] col);
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_a in_ready: got %b want 1", a_in_ready);
        end
        a_in_valid = 1'b1;
        a_col      = col;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [0:8][7:0] col);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_col      = col;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic push_c(input logic [0:8][7:0] col);
        @(negedge clk);
        c_in_valid = 1'b1;
        c_col      = col;
        @(posedge clk);
        #1;
        c_in_valid = 1'b0;
    endtask

    // Drain dut_a against ref_img; optional random stalls and ignored input noise.
    task automatic drain_a(input string nm, input bit stalls, input bit noise);
        int          idx = 0;
        int          guard = 0;
        bit          was_stall = 0;
        logic [11:0] held = '0;
        while (idx < 16 && guard < 400) begin
            @(negedge clk);
            guard++;
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s drain handshake idx=%0d: got valid=%b in_ready=%b want 1/0",
                         nm, idx, a_out_valid, a_in_ready);
            end
            if (was_stall) begin
                checks++;
                if (a_pix !== held) begin
                    errors++;
                    $display("FAIL %s stall stability idx=%0d: got %0d want %0d",
                             nm, idx, a_pix, held);
                end
            end
            if (noise) begin
                a_in_valid = 1'($urandom_range(0, 1));
                a_col      = rand_col();
            end
            a_out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (a_out_ready) begin
                checks++;
                if (a_pix !== 12'(ref_img[idx]) || a_last !== (idx == 15)) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got %0d last=%b want %0d last=%b",
                             nm, idx, a_pix, a_last, ref_img[idx], (idx == 15));
                end
                idx++;
                was_stall = 0;
            end else begin
                held      = a_pix;
                was_stall = 1;
            end
        end
        if (idx < 16) begin
            errors++;
            $display("FAIL %s drain timeout: got %0d pixels want 16", nm, idx);
        end
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post-drain: got valid=%b busy=%b in_ready=%b want 0/0/1",
                     nm, a_out_valid, a_busy, a_in_ready);
        end
    endtask

    task automatic drain_b(input string nm);
        int idx = 0;
        int guard = 0;
        b_out_ready = 1'b1;
        while (idx < 25 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (b_out_valid === 1'b1) begin
                checks++;
                if (b_pix !== 12'(ref_img[idx]) || b_last !== (idx == 24)) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got %0d last=%b want %0d last=%b",
                             nm, idx, b_pix, b_last, ref_img[idx], (idx == 24));
                end
                idx++;
            end
        end
        if (idx < 25) begin
            errors++;
            $display("FAIL %s drain timeout: got %0d pixels want 25", nm, idx);
        end
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_pix !== 12'd0 || a_last !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got valid=%b busy=%b pix=%0d last=%b want 0/0/0/0",
                     a_out_valid, a_busy, a_pix, a_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b%b%b want 111", a_in_ready, b_in_ready, c_in_ready);
        end
    endtask

    // Four all-ones columns, checking busy and the one-cycle drain latency.
    task automatic frame_ones_a(input string nm);
        ref_clear();
        for (int p = 0; p < 4; p++) begin
            push_a(fill_col(1));
            ref_scatter(4, 1, 2, p, fill_col(1), 12);
            checks++;
            if (p < 3 && (a_out_valid !== 1'b0 || a_busy !== 1'b1)) begin
                errors++;
                $display("FAIL %s accum col %0d: got valid=%b busy=%b want 0/1",
                         nm, p, a_out_valid, a_busy);
            end else if (p == 3 && a_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s drain latency: got valid=%b want 1", nm, a_out_valid);
            end
        end
        drain_a(nm, 1'b0, 1'b0);
    endtask

    task automatic test_overlap_default();
        frame_ones_a("overlap");
    endtask

    task automatic test_stride2();
        logic [0:8][7:0] c;
        ref_clear();
        for (int p = 0; p < 4; p++) begin
            c = fill_col(p + 1);
            push_b(c);
            ref_scatter(5, 2, 2, p, c, 12);
        end
        drain_b("stride2 frame1");
        ref_clear();
        for (int p = 0; p < 4; p++) begin
            push_b(fill_col(1));
            ref_scatter(5, 2, 2, p, fill_col(1), 12);
        end
        drain_b("stride2 frame2");
    endtask

    task automatic test_back_to_back_random();
        logic [0:8][7:0] c;
        for (int f = 0; f < 3; f++) begin
            ref_clear();
            for (int p = 0; p < 4; p++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                c = rand_col();
                push_a(c);
                ref_scatter(4, 1, 2, p, c, 12);
            end
            drain_a("random", 1'b1, 1'b1);
        end
    endtask

    task automatic test_wrap();
        int idx = 0;
        int guard = 0;
        ref_clear();
        for (int p = 0; p < 4; p++) begin
            push_c(fill_col(255));
            ref_scatter(4, 1, 2, p, fill_col(255), 9);
        end
        c_out_ready = 1'b1;
        while (idx < 16 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (c_out_valid === 1'b1) begin
                checks++;
                if (c_pix !== 9'(ref_img[idx])) begin
                    errors++;
                    $display("FAIL wrap pixel %0d: got %0d want %0d", idx, c_pix, ref_img[idx]);
                end
                idx++;
            end
        end
        if (idx < 16) begin
            errors++;
            $display("FAIL wrap drain timeout: got %0d pixels want 16", idx);
        end
        @(negedge clk);
        c_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_a(fill_col(7));
        push_a(fill_col(9));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL async reset accum: got busy=%b want 0", a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_ones_a("after partial reset");
        for (int p = 0; p < 4; p++) push_a(fill_col(5));
        @(negedge clk);
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid-drain setup: got valid=%b want 1", a_out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_last !== 1'b0) begin
            errors++;
            $display("FAIL async reset drain: got valid=%b busy=%b last=%b want 0/0/0",
                     a_out_valid, a_busy, a_last);
        end
        @(negedge clk);
        a_out_ready = 1'b0;
        rst_n = 1'b1;
        frame_ones_a("after drain reset");
    endtask

    initial begin
        a_in_valid = 0; a_out_ready = 0; a_col = '0;
        b_in_valid = 0; b_out_ready = 0; b_col = '0;
        c_in_valid = 0; c_out_ready = 0; c_col = '0;
        test_reset();
        test_overlap_default();
        test_stride2();
        test_back_to_back_random();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/col2im_2d.md
Name: col2im_2d

Overview:
- Streaming inverse of the im2col unfold.
- Accepts one unfolded column per handshake: KERNEL_SIZE*KERNEL_SIZE values belonging to one kernel position.
- Scatter-adds each value into the image-sized accumulator buffer. Overlapping patches sum.
- After the last position, drains the reconstructed image row-major through a valid/ready output port. Sits after the MAC array, e.g. for gradient / overlap-add reconstruction.

Parameters:
- IMAGE_WIDTH, 4, reconstructed image width in pixels.
- IMAGE_HEIGHT, 4, reconstructed image height in pixels.
- KERNEL_SIZE, 3, square kernel edge.
- STRIDE, 1, kernel step in both axes. Padding is fixed at 0.
- DATA_WIDTH, 8, unsigned input element width.
- ACC_WIDTH, 12, unsigned accumulator and output width. Must be >= DATA_WIDTH.
- HORIZONTAL_POSITIONS, (IMAGE_WIDTH-KERNEL_SIZE)/STRIDE+1, derived.
- VERTICAL_POSITIONS, (IMAGE_HEIGHT-KERNEL_SIZE)/STRIDE+1, derived.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_column is valid.
- in_ready  output  1  block can accept a column.
- in_column  input  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  packed [0:K*K-1][DATA_WIDTH-1:0]. Element i sits at patch offset (i/K, i%K).
- out_valid  output  1  out_pixel is valid.
- out_ready  input  1  downstream accepts out_pixel.
- out_pixel  output  ACC_WIDTH  accumulated pixel value.
- out_last  output  1  high with the final pixel, index H*W-1.
- busy  output  1  high unless idle in ACCUM with pos=0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - state=ACCUM
  - all accumulators 0
  - pos_x=pos_y=0, drain index=0
  - out_valid=0, out_last=0, out_pixel=0, busy=0
  - in_ready=1 once rst_n deasserts
- States: ACCUM and DRAIN.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, for every i: acc[pos_y*STRIDE + i/K][pos_x*STRIDE + i%K] += in_column[i], zero-extended. All K*K updates land in the same cycle; the targets within one column are distinct.
  - Position order is raster: pos_x increments. Wrap at HORIZONTAL_POSITIONS-1 to 0 and increment pos_y.
  - Accepting the column at pos_x=H_POS-1, pos_y=V_POS-1 resets the counters and moves to DRAIN on the next cycle.
- DRAIN:
  - in_ready=0.
  - out_valid=1 and out_pixel=acc[idx], where idx runs 0..H*W-1 in row-major order (row*IMAGE_WIDTH + col).
  - out_pixel is registered or muxed from the buffer, but must be stable while out_valid && !out_ready.
  - On out_valid&&out_ready: acc[idx] is cleared to 0, and idx increments.
  - On the last pixel: out_last=1, then return to ACCUM with idx=0. The buffer is then fully zero, so no separate clear pass is needed.
- Latency: first out_valid appears exactly 1 cycle after the final column handshake. Drain throughput is 1 pixel/cycle with out_ready held high.
- Pixels covered by no patch (STRIDE > KERNEL_SIZE, or a right/bottom remainder) drain as 0.
- Arithmetic: unsigned. Default overflow behaviour is wrap modulo 2^ACC_WIDTH.
- in_valid while in DRAIN is ignored. No data is lost, because in_ready=0.
- out_ready while in ACCUM has no effect.
- Reset mid-operation (either state): the partial image is discarded, and all registers return to their reset values immediately.

Optional Feature:
- Macro: COL2IM_SATURATE_EN.
- Defined: each accumulator update clamps at 2^ACC_WIDTH-1 instead of wrapping. The per-pixel sum is computed one bit wider and then clamped.
- Undefined: plain modular addition, no extra logic.

Test Plan:
- Defaults (4x4, K=3, S=1), 4 columns of all 1s, out_ready=1 -> 16 pixels in order: 1 2 2 1 / 2 4 4 2 / 2 4 4 2 / 1 2 2 1. out_last only on the 16th. First out_valid 1 cycle after the 4th handshake.
- 5x5, K=3, S=2, column p filled with value p+1 -> (0,0)=1, (2,2)=1+2+3+4=10, (4,4)=4, (0,2)=1+2=3. All other uncovered-by-none checks are per the overlap map. A following second frame of all-1s columns produces a fresh overlap map, proving clear-on-drain.
- Defaults, random in_valid gaps during ACCUM and random out_ready stalls during DRAIN -> identical output sequence to a reference model. out_pixel is stable during stalls. in_ready=0 throughout DRAIN.
- ACC_WIDTH=9, all elements 255, defaults -> center pixel: 4*255=1020 wraps to 508. With COL2IM_SATURATE_EN it reads 511. Corner pixel is 255 in both builds.
- rst_n pulled low after 2 of 4 columns, then a full 4-column all-1s frame -> output equals the first scenario, showing no residue from the partial frame. Asynchronous: out_valid and busy drop without waiting for a clk edge.
